// File: rtl/mac_accum_if.sv
// Product-in / sum-out handshake bundle for mac_accum.
// The master drives products and consumes sums; the slave is the accumulator.
interface mac_accum_if #(
    parameter int ACC_W = 12
);
    logic [7:0]       in_prod;
    logic             in_valid;
    logic             in_ready;
    logic             in_clear;
    logic [ACC_W-1:0] out_sum;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_prod, in_valid, in_clear, out_ready,
        input  in_ready, out_sum, out_valid
    );

    modport slave (
        input  in_prod, in_valid, in_clear, out_ready,
        output in_ready, out_sum, out_valid
    );
endinterface

// File: rtl/mac_accum.sv
// Sums LEN unsigned 8-bit products, then holds the result until the consumer takes it.
// in_clear aborts everything synchronously and wins over any other input.
module mac_accum #(
    parameter int LEN   = 4,
    parameter int ACC_W = 12
) (
    input  logic      clk,
    input  logic      rst_n,
    mac_accum_if.slave bus
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] sum;
    logic             sum_vld;
    logic             ready;
    logic             accept;
    logic             last;
    logic             take;

    assign accept = bus.in_valid & ready & ~bus.in_clear;
    assign last   = accept & (cnt == LAST);
    assign take   = sum_vld & bus.out_ready & ~bus.in_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.in_clear) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (last) state_nxt = HOLD;
                HOLD:    if (take) state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    // in_ready depends on registered state only, so no input-to-output path
    always_comb begin
        ready = (state == ACCUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            sum     <= '0;
            sum_vld <= 1'b0;
        end else if (bus.in_clear) begin
            acc     <= '0;
            cnt     <= '0;
            sum_vld <= 1'b0;
        end else if (last) begin
            sum     <= acc + ACC_W'(bus.in_prod);
            acc     <= '0;
            cnt     <= '0;
            sum_vld <= 1'b1;
        end else if (accept) begin
            acc <= acc + ACC_W'(bus.in_prod);
            cnt <= cnt + CNT_W'(1);
        end else if (take) begin
            sum_vld <= 1'b0;
        end
    end

    // sum keeps its last value after the handshake; out_valid alone qualifies it
    assign bus.in_ready  = ready;
    assign bus.out_sum   = sum;
    assign bus.out_valid = sum_vld;
endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter LEN, default 4, meaning number of products summed per result; legal range 1..16.
REQ-002 SHALL have parameter ACC_W, default 12, meaning accumulator/result width; SHALL be >= 8 + ceil(log2(LEN)), so no overflow is possible.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_prod  input  8  unsigned product from the upstream 4x4 multiplier.
REQ-006 in_valid  input  1  in_prod is valid this cycle.
REQ-007 in_ready  output  1  block can accept a product this cycle.
REQ-008 in_clear  input  1  synchronous abort of the current accumulation.
REQ-009 out_sum  output  ACC_W  unsigned sum of LEN accepted products.
REQ-010 out_valid  output  1  out_sum is valid.
REQ-011 out_ready  input  1  downstream accepts out_sum this cycle.

Function
REQ-012 SHALL implement two states: ACCUM (collecting products) and HOLD (presenting a result).
REQ-013 in_ready SHALL be 1 in ACCUM and 0 in HOLD, decoded from registered state only, with no combinational path from any input.
REQ-014 A product is accepted only on a cycle with in_valid=1, in_ready=1 and in_clear=0; otherwise acc and cnt are unchanged.
REQ-015 On accept with cnt < LEN-1: acc <= acc + zero-extended in_prod; cnt <= cnt + 1.
REQ-016 On accept with cnt = LEN-1: out_sum <= acc + in_prod; acc <= 0; cnt <= 0; out_valid <= 1; state <= HOLD.
REQ-017 Latency: out_valid SHALL rise on the first cycle after the LEN-th accepted product.
REQ-018 Gaps in in_valid between products SHALL not affect the result.
REQ-019 In HOLD, out_sum and out_valid SHALL stay stable until a cycle with out_valid=1 and out_ready=1.
REQ-020 On that handshake cycle: out_valid <= 0; state <= ACCUM. in_ready returns to 1 on the next cycle; no product is accepted during the handshake cycle.
REQ-021 out_sum SHALL retain its last value after the handshake; it is qualified only by out_valid.
REQ-022 in_clear=1 SHALL take priority over every other input, in any state:
  - acc <= 0; cnt <= 0; out_valid <= 0; state <= ACCUM;
  - a pending result in HOLD is discarded;
  - a product presented in the same cycle is dropped.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 With LEN=1, every accepted product SHALL produce a result equal to that product, one cycle later.

Reset
REQ-025 While rst_n=0, outputs SHALL take these values regardless of clk: state=ACCUM, acc=0, cnt=0, out_sum=0, out_valid=0, in_ready=1.
REQ-026 Reset asserted mid-accumulation or in HOLD SHALL discard all partial and pending results.
REQ-027 The first product can be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-028 LEN=4, products 225,225,225,225 on back-to-back cycles, out_ready=1 -> out_valid high one cycle after the 4th accept, out_sum=900, in_ready=0 for that cycle.
REQ-029 Products 1,2,3,4 with 2-cycle in_valid gaps -> out_sum=10; in_ready=1 throughout accumulation.
REQ-030 Result ready, out_ready held 0 for 5 cycles while in_valid=1 with product 7 -> out_sum stable, in_ready=0, no accepts; after the handshake, the next four 7s give out_sum=28.
REQ-031 Two products 100,50, then in_clear with in_valid=1 and product 9, then products 1,1,1,1 -> out_sum=4.
REQ-032 rst_n pulsed low during HOLD (out_sum=900) -> out_valid=0 and out_sum=0 immediately, without waiting for a clock edge; the next four products 2 give out_sum=8.
REQ-033 LEN=1, products 5 then 255 -> two results, 5 then 255, each one cycle after its accept.
